// File: rtl/mac_operand_fetch.sv
// mac_operand_fetch: collects Rm, Rs and (for MLA) Rn from a two-port
// combinational register file. It then presents them as one operand set to the
// MAC stage with a valid/ready handshake.
// Optional feature: define MAC_OPERAND_FWD_EN to forward the writeback bus
// onto each read port independently during the fetch states.
module mac_operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_rm,
  input  logic [3:0]  cmd_rs,
  input  logic [3:0]  cmd_rn,
  input  logic [3:0]  cmd_rd,
  input  logic        cmd_acc,
  input  logic        cmd_s,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  input  logic [31:0] rf_ra_data,
  input  logic [31:0] rf_rb_data,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_in1,
  output logic [31:0] op_in2,
  output logic [31:0] op_acc,
  output logic [3:0]  op_rd,
  output logic        op_s
);

  typedef enum logic [1:0] {IDLE, FETCH_MS, FETCH_N, HOLD} state_t;

  state_t      state, state_nxt;
  logic        cmd_take;

  // command fields latched on accept
  logic [3:0]  rm_p0, rs_p0, rn_p0, rd_p0;
  logic        acc_p0, s_p0;

  // read-port values after the optional forwarding mux
  logic [31:0] ra_val, rb_val;

`ifdef MAC_OPERAND_FWD_EN
  // A matching writeback overrides the register-file data on that port only
  function automatic logic [31:0] fwd_sel(input logic [3:0] addr,
                                          input logic [31:0] rf_data,
                                          input logic fwd_en,
                                          input logic [3:0] fwd_addr,
                                          input logic [31:0] fwd_data);
    if (fwd_en && (fwd_addr == addr))
      return fwd_data;
    return rf_data;
  endfunction

  assign ra_val = fwd_sel(rf_ra_addr, rf_ra_data, wb_en, wb_addr, wb_data);
  assign rb_val = fwd_sel(rf_rb_addr, rf_rb_data, wb_en, wb_addr, wb_data);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
  assign ra_val    = rf_ra_data;
  assign rb_val    = rf_rb_data;
`endif

  assign op_rd = rd_p0;
  assign op_s  = s_p0;

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state, handshake and read-address decode
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    cmd_take   = 1'b0;
    op_valid   = 1'b0;
    rf_ra_addr = 4'd0;
    rf_rb_addr = 4'd0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_take  = 1'b1;
          state_nxt = FETCH_MS;
        end
      end
      FETCH_MS: begin
        rf_ra_addr = rm_p0;
        rf_rb_addr = rs_p0;
        state_nxt  = acc_p0 ? FETCH_N : HOLD;
      end
      FETCH_N: begin
        rf_ra_addr = rn_p0;
        state_nxt  = HOLD;
      end
      HOLD: begin
        op_valid = 1'b1;
        if (op_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command latch and operand capture; everything held while in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      rm_p0  <= 4'd0;
      rs_p0  <= 4'd0;
      rn_p0  <= 4'd0;
      rd_p0  <= 4'd0;
      acc_p0 <= 1'b0;
      s_p0   <= 1'b0;
      op_in1 <= 32'd0;
      op_in2 <= 32'd0;
      op_acc <= 32'd0;
    end else begin
      if (cmd_take) begin
        rm_p0  <= cmd_rm;
        rs_p0  <= cmd_rs;
        rn_p0  <= cmd_rn;
        rd_p0  <= cmd_rd;
        acc_p0 <= cmd_acc;
        s_p0   <= cmd_s;
      end
      case (state)
        FETCH_MS: begin
          op_in1 <= ra_val;
          op_in2 <= rb_val;
          if (!acc_p0)
            op_acc <= 32'd0;
        end
        FETCH_N: op_acc <= ra_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_fetch.sv
// Randomized self-checking bench for mac_operand_fetch with directed corner
// cases. Expected operands come from a register-file array and the writeback
// bus, which is honoured only when MAC_OPERAND_FWD_EN is defined.
module tb_mac_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_rm, cmd_rs, cmd_rn, cmd_rd;
  logic        cmd_acc, cmd_s;
  logic [3:0]  rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_ra_data, rf_rb_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_in1, op_in2, op_acc;
  logic [3:0]  op_rd;
  logic        op_s;

  logic [31:0] rf [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  mac_operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rm     (cmd_rm),
    .cmd_rs     (cmd_rs),
    .cmd_rn     (cmd_rn),
    .cmd_rd     (cmd_rd),
    .cmd_acc    (cmd_acc),
    .cmd_s      (cmd_s),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_in1     (op_in1),
    .op_in2     (op_in2),
    .op_acc     (op_acc),
    .op_rd      (op_rd),
    .op_s       (op_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // value an operand should receive when its register number is addr
  function automatic logic [31:0] model_read(input logic [3:0] addr);
`ifdef MAC_OPERAND_FWD_EN
    if (wb_en && (wb_addr == addr))
      return wb_data;
`endif
    return rf[addr];
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"},  32'(op_valid),   32'd0);
    chk({tag, "_ready"},  32'(cmd_ready),  32'd1);
    chk({tag, "_in1"},    op_in1,          32'd0);
    chk({tag, "_in2"},    op_in2,          32'd0);
    chk({tag, "_acc"},    op_acc,          32'd0);
    chk({tag, "_rd"},     32'(op_rd),      32'd0);
    chk({tag, "_s"},      32'(op_s),       32'd0);
    chk({tag, "_ra"},     32'(rf_ra_addr), 32'd0);
    chk({tag, "_rb"},     32'(rf_rb_addr), 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input logic [3:0] rm, input logic [3:0] rs,
                        input logic [3:0] rn, input logic [3:0] rd,
                        input logic acc, input logic s, input int stall);
    logic [31:0] e1, e2, ea;
    int lat;
    e1  = model_read(rm);
    e2  = model_read(rs);
    ea  = acc ? model_read(rn) : 32'd0;
    lat = acc ? 3 : 2;
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_rm = rm; cmd_rs = rs; cmd_rn = rn; cmd_rd = rd;
    cmd_acc = acc; cmd_s = s;
    cmd_valid = 1'b1;
    op_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // scramble the command bus; it must be ignored until IDLE again
    cmd_valid = 1'($urandom);
    cmd_rm = 4'($urandom); cmd_rs = 4'($urandom); cmd_rn = 4'($urandom);
    cmd_rd = 4'($urandom); cmd_acc = 1'($urandom); cmd_s = 1'($urandom);
    for (int k = 1; k < lat; k++) begin
      chk("fetch_valid", 32'(op_valid),  32'd0);
      chk("fetch_ready", 32'(cmd_ready), 32'd0);
      if (k == 1) begin
        chk("ms_ra", 32'(rf_ra_addr), 32'(rm));
        chk("ms_rb", 32'(rf_rb_addr), 32'(rs));
      end else begin
        chk("n_ra", 32'(rf_ra_addr), 32'(rn));
        chk("n_rb", 32'(rf_rb_addr), 32'd0);
      end
      @(negedge clk);
    end
    for (int i = 0; i <= stall; i++) begin
      chk("hold_valid", 32'(op_valid),   32'd1);
      chk("hold_ready", 32'(cmd_ready),  32'd0);
      chk("hold_in1",   op_in1,          e1);
      chk("hold_in2",   op_in2,          e2);
      chk("hold_acc",   op_acc,          ea);
      chk("hold_rd",    32'(op_rd),      32'(rd));
      chk("hold_s",     32'(op_s),       32'(s));
      chk("hold_ra",    32'(rf_ra_addr), 32'd0);
      if (i < stall)
        @(negedge clk);
    end
    cmd_valid = 1'b0;
    op_ready  = 1'b1;
    @(negedge clk);
    chk("done_valid", 32'(op_valid),  32'd0);
    chk("done_ready", 32'(cmd_ready), 32'd1);
    op_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; op_ready = 1'b0;
    cmd_rm = 4'd0; cmd_rs = 4'd0; cmd_rn = 4'd0; cmd_rd = 4'd0;
    cmd_acc = 1'b0; cmd_s = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    for (int r = 0; r < 16; r++) rf[r] = 32'(r) * 32'h0101_0101 + 32'h11;

    do_reset();
    check_cleared("reset");

    // MUL R1*R2
    rf[1] = 32'd7; rf[2] = 32'd6;
    run_op(4'd1, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0, 0);

    // MLA with all-ones multiplicand and S set
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd2; rf[4] = 32'd5;
    run_op(4'd1, 4'd2, 4'd4, 4'd6, 1'b1, 1'b1, 0);

    // MLA stalled five cycles by the MAC stage
    run_op(4'd1, 4'd2, 4'd4, 4'd9, 1'b1, 1'b0, 5);

    // MUL after MLA: accumulator must go back to zero
    run_op(4'd2, 4'd1, 4'd4, 4'd2, 1'b0, 1'b1, 1);

    // same register for both multiplier operands
    rf[5] = 32'd3;
    run_op(4'd5, 4'd5, 4'd5, 4'd1, 1'b0, 1'b0, 0);
    run_op(4'd5, 4'd5, 4'd5, 4'd1, 1'b1, 1'b0, 0);

    // R15 is read like any other register
    rf[15] = 32'hCAFE_F00D;
    run_op(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 2);

    // writeback on R2 during fetch: forwarded only in the forwarding build
    rf[2] = 32'd6;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h10;
    run_op(4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 0);
    run_op(4'd2, 4'd3, 4'd2, 4'd7, 1'b1, 1'b0, 0);
    wb_en = 1'b0;

    // reset while in FETCH_N drops the operation
    rf[1] = 32'h1234; rf[2] = 32'h5678; rf[4] = 32'h9ABC;
    cmd_rm = 4'd1; cmd_rs = 4'd2; cmd_rn = 4'd4; cmd_rd = 4'd8;
    cmd_acc = 1'b1; cmd_s = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ra", 32'(rf_ra_addr), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_novalid", 32'(op_valid), 32'd0);
    end

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [3:0] rm, rs, rn;
      int pick;
      for (int r = 0; r < 16; r++) rf[r] = $urandom;
      rm = 4'($urandom); rs = 4'($urandom); rn = 4'($urandom);
      wb_en   = 1'($urandom);
      wb_data = $urandom;
      pick    = int'($urandom_range(3, 0));
      wb_addr = (pick == 0) ? rm : (pick == 1) ? rs : (pick == 2) ? rn : 4'($urandom);
      run_op(rm, rs, rn, 4'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
